// File: rtl/keyboard_tracker.sv
// PS/2 device-to-host receiver with Set-2 make/break decoding for W/A/S/D,
// arrows, Space and Enter; outputs are either held key states or press pulses.
module keyboard_tracker #(
    parameter int PULSE_OR_HOLD = 0,
    parameter int TIMEOUT       = 50000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    inout  wire  PS2_CLK,
    inout  wire  PS2_DAT,
    output logic w,
    output logic a,
    output logic s,
    output logic d,
    output logic left,
    output logic right,
    output logic up,
    output logic down,
    output logic space,
    output logic enter
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    // Key vector order: {enter, space, down, up, right, left, d, s, a, w}
    localparam int NKEYS = 10;

    assign PS2_CLK = 1'bz;
    assign PS2_DAT = 1'bz;

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    logic [3:0]    bit_cnt;
    logic [9:0]    frame;
    logic [TW-1:0] to_cnt;
    logic          frame_ok;
    logic          byte_valid;
    logic          byte_err;
    logic [7:0]    rx_byte;

    logic             ext, brk;
    logic [NKEYS-1:0] key_hit;
    logic [NKEYS-1:0] held;
    logic [NKEYS-1:0] pulse_q;
    logic [NKEYS-1:0] out_vec;

    // Synchronizers are left unreset so edge detection keeps tracking the pins
    // through reset; a reset cycle can therefore never fabricate a falling edge.
    always_ff @(posedge CLOCK_50) begin
        clk_s1   <= PS2_CLK;
        clk_s2   <= clk_s1;
        clk_prev <= clk_s2;
        dat_s1   <= PS2_DAT;
        dat_s2   <= dat_s1;
    end

    assign fall = clk_prev & ~clk_s2;

    // frame[0] is the start bit, frame[8:1] the data byte, frame[9] parity;
    // the stop bit is taken straight from the synchronizer on the 11th edge.
    assign frame_ok = ~frame[0] & dat_s2 & (^frame[9:1]);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            bit_cnt    <= '0;
            frame      <= '0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            rx_byte    <= '0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    rx_byte <= frame[8:1];
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                    end else begin
                        byte_err <= 1'b1;
                    end
                end else begin
                    frame[bit_cnt] <= dat_s2;
                    bit_cnt        <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TO_LAST) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        key_hit = '0;
        if (!ext) begin
            case (rx_byte)
                8'h1D:   key_hit[0] = 1'b1;
                8'h1C:   key_hit[1] = 1'b1;
                8'h1B:   key_hit[2] = 1'b1;
                8'h23:   key_hit[3] = 1'b1;
                8'h29:   key_hit[8] = 1'b1;
                8'h5A:   key_hit[9] = 1'b1;
                default: key_hit = '0;
            endcase
        end else begin
            case (rx_byte)
                8'h6B:   key_hit[4] = 1'b1;
                8'h74:   key_hit[5] = 1'b1;
                8'h75:   key_hit[6] = 1'b1;
                8'h72:   key_hit[7] = 1'b1;
                8'h5A:   key_hit[9] = 1'b1;
                default: key_hit = '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            held    <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            if (byte_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (brk) begin
                        held <= held & ~key_hit;
                    end else begin
                        held    <= held | key_hit;
                        pulse_q <= key_hit & ~held;
                    end
                end
            end
        end
    end

    assign out_vec = (PULSE_OR_HOLD != 0) ? pulse_q : held;
    assign {enter, space, down, up, right, left, d, s, a, w} = out_vec;

endmodule

// File: tb/tb_keyboard_tracker.sv
// Directed bench driving a hold-mode and a pulse-mode keyboard_tracker from one
// PS/2 pin pair, checked every cycle against a table-driven key-state model.
`timescale 1ns/1ps
module tb_keyboard_tracker;

    localparam int HALF = 40;
    localparam int TO   = 300;

    localparam int CODES_NORM [10] = '{'h1D, 'h1C, 'h1B, 'h23, -1, -1, -1, -1, 'h29, 'h5A};
    localparam int CODES_EXT  [10] = '{-1, -1, -1, -1, 'h6B, 'h74, 'h75, 'h72, -1, 'h5A};

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    logic clk_drv  = 1'b1;
    logic dat_drv  = 1'b1;
    wire  ps2_clk;
    wire  ps2_dat;
    assign ps2_clk = clk_drv;
    assign ps2_dat = dat_drv;

    logic h_w, h_a, h_s, h_d, h_left, h_right, h_up, h_down, h_space, h_enter;
    logic p_w, p_a, p_s, p_d, p_left, p_right, p_up, p_down, p_space, p_enter;
    logic [9:0] hold_vec, pulse_vec;
    assign hold_vec  = {h_enter, h_space, h_down, h_up, h_right, h_left, h_d, h_s, h_a, h_w};
    assign pulse_vec = {p_enter, p_space, p_down, p_up, p_right, p_left, p_d, p_s, p_a, p_w};

    keyboard_tracker #(.PULSE_OR_HOLD(0), .TIMEOUT(TO)) dut_hold (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .w(h_w), .a(h_a), .s(h_s), .d(h_d), .left(h_left), .right(h_right),
        .up(h_up), .down(h_down), .space(h_space), .enter(h_enter)
    );

    keyboard_tracker #(.PULSE_OR_HOLD(1), .TIMEOUT(TO)) dut_pulse (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .w(p_w), .a(p_a), .s(p_s), .d(p_d), .left(p_left), .right(p_right),
        .up(p_up), .down(p_down), .space(p_space), .enter(p_enter)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_stop = 0;
    int w_pulses = 0;

    // Model state
    logic [9:0] exp_hold  = '0;
    logic [9:0] exp_pulse = '0;
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic int key_index(input logic [7:0] code, input bit ext);
        for (int i = 0; i < 10; i++) begin
            if ((ext ? CODES_EXT[i] : CODES_NORM[i]) == int'(code)) return i;
        end
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            idx = key_index(b, m_ext);
            if (idx >= 0) begin
                if (m_brk) exp_hold[idx] = 1'b0;
                else begin
                    if (!exp_hold[idx]) exp_pulse[idx] = 1'b1;
                    exp_hold[idx] = 1'b1;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Continuous comparison; a short window after each stop edge allows latency.
    logic [9:0] pulse_seen = '0;
    logic [9:0] prev_pulse = '0;
    int diff;
    always @(negedge CLOCK_50) begin
        diff = cyc - last_stop;
        if (p_w) w_pulses++;
        if (diff <= 6) begin
            pulse_seen |= pulse_vec;
            check("pulse_width", pulse_vec & prev_pulse, '0);
        end else begin
            if (diff == 7) begin
                check("pulse_events", pulse_seen, exp_pulse);
                pulse_seen = '0;
            end
            check("hold_state", hold_vec, exp_hold);
            check("pulse_idle", pulse_vec, '0);
        end
        prev_pulse = pulse_vec;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dat_drv = f[i];
            wait_cyc(HALF);
            clk_drv = 1'b0;
            if (i == 10) begin
                exp_pulse = '0;
                if (!bad_par && !bad_stop) model_byte(b);
                else begin
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end
                last_stop = cyc;
            end
            wait_cyc(HALF);
            clk_drv = 1'b1;
        end
        dat_drv = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    initial begin
        wait_cyc(5);
        check("reset_hold", hold_vec, '0);
        check("reset_pulse", pulse_vec, '0);
        resetn = 1'b1;
        last_stop = cyc;
        wait_cyc(10);

        // Hold mode: A press and release
        send(8'h1C);
        check("a_press", hold_vec, 10'b00_0000_0010);
        send(8'hF0); send(8'h1C);
        check("a_release", hold_vec, '0);

        // Extended left; keypad 6B ignored
        send(8'hE0); send(8'h6B);
        check("left_press", hold_vec, 10'b00_0001_0000);
        send(8'h6B);
        check("keypad_ignored", hold_vec, 10'b00_0001_0000);
        send(8'hE0); send(8'hF0); send(8'h6B);
        check("left_release", hold_vec, '0);

        // Pulse mode: press, repeat, release, press
        send(8'h1D);
        send(8'h1D);
        check("w_held", hold_vec, 10'b00_0000_0001);
        send(8'hF0); send(8'h1D);
        send(8'h1D);
        check("w_pulse_count", 10'(w_pulses), 10'd2);
        send(8'hF0); send(8'h1D);

        // Bad parity then valid D
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        send(8'h23);
        check("bad_parity", hold_vec, 10'b00_0000_1000);
        send(8'hF0); send(8'h23);
        // Bad stop then valid S
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        send(8'h1B);
        check("bad_stop", hold_vec, 10'b00_0000_0100);
        send(8'hF0); send(8'h1B);
        // Bad frame clears the E0 prefix so 6B is a keypad code
        send(8'hE0);
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        send(8'h6B);
        check("bad_clears_ext", hold_vec, '0);

        // Partial frame, timeout, then Space
        send_frame(8'h29, 1'b0, 1'b0, 5);
        wait_cyc(TO + 100);
        send(8'h29);
        check("timeout_space", hold_vec, 10'b01_0000_0000);

        // Reset mid-frame while holding keys
        send(8'h1C); send(8'h5A);
        check("multi_hold", hold_vec, 10'b11_0000_0010);
        send_frame(8'h75, 1'b0, 1'b0, 4);
        resetn = 1'b0;
        exp_hold = '0;
        exp_pulse = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        last_stop = cyc;
        wait_cyc(1);
        resetn = 1'b1;
        check("reset_mid_hold", hold_vec, '0);
        check("reset_mid_pulse", pulse_vec, '0);
        send(8'h5A);
        check("enter_after_reset", hold_vec, 10'b10_0000_0000);
        send(8'hE0); send(8'h5A);
        check("kp_enter_repeat", hold_vec, 10'b10_0000_0000);

        wait_cyc(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
